// File: rtl/zap_prefetch_buffer.sv
// zap_prefetch_buffer: instruction prefetch FIFO feeding decode with a registered output stage.
// Define ZAP_PREFETCH_BYPASS_EN to load the output registers directly from fetch when the FIFO is empty.
module zap_prefetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clear_from_writeback,
    input  logic                       i_data_stall,
    input  logic                       i_clear_from_alu,
    input  logic                       i_stall_from_shifter,
    input  logic                       i_stall_from_issue,
    input  logic                       i_fetch_valid,
    input  logic [31:0]                i_fetch_instr,
    input  logic [31:0]                i_fetch_pc,
    input  logic                       i_fetch_abt,
    input  logic [1:0]                 i_fetch_taken,
    output logic                       o_fetch_ready,
    output logic [35:0]                o_instruction,
    output logic                       o_instruction_valid,
    output logic [31:0]                o_pc_ff,
    output logic [31:0]                o_pc_plus_8_ff,
    output logic                       o_abt_ff,
    output logic [1:0]                 o_taken_ff,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc [DEPTH];
    logic        mem_abt [DEPTH];
    logic [1:0]  mem_taken [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0] instr_ff, nxt_pc;
    logic flush, hold, adv, push, pop, wr, byp;
    assign flush = i_clear_from_writeback | (i_clear_from_alu & !i_data_stall);
    assign hold = !flush & (i_data_stall | i_stall_from_shifter | i_stall_from_issue);
    assign adv = !flush & !hold;
    assign o_fetch_ready = !i_reset && count != CW'(DEPTH);
    assign push = i_fetch_valid & o_fetch_ready & !flush;
`ifdef ZAP_PREFETCH_BYPASS_EN
    assign byp = adv & push & (count == '0);
`else
    assign byp = 1'b0;
`endif
    // A bypassed word goes straight to the output stage and never occupies a slot.
    assign wr = push & !byp;
    assign pop = adv & (count != '0);
    assign nxt_pc = byp ? i_fetch_pc : mem_pc[rd_ptr];
    assign o_instruction = {4'd0, instr_ff};
    assign o_count = count;
    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem_instr[wr_ptr] <= i_fetch_instr;
            mem_pc[wr_ptr] <= i_fetch_pc;
            mem_abt[wr_ptr] <= i_fetch_abt;
            mem_taken[wr_ptr] <= i_fetch_taken;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr_ff <= '0;
            o_instruction_valid <= 1'b0;
            o_pc_ff <= '0;
            o_pc_plus_8_ff <= '0;
            o_abt_ff <= 1'b0;
            o_taken_ff <= '0;
        end else if (flush) begin
            o_instruction_valid <= 1'b0;
            o_abt_ff <= 1'b0;
            o_taken_ff <= '0;
        end else if (adv) begin
            o_instruction_valid <= pop | byp;
            if (pop | byp) begin
                instr_ff <= byp ? i_fetch_instr : mem_instr[rd_ptr];
                o_pc_ff <= nxt_pc;
                o_pc_plus_8_ff <= nxt_pc + 32'd8;
                o_abt_ff <= byp ? i_fetch_abt : mem_abt[rd_ptr];
                o_taken_ff <= byp ? i_fetch_taken : mem_taken[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_zap_prefetch_buffer.sv
// tb_zap_prefetch_buffer: scoreboard bench; accepted fetch words are queued and matched
// against every instruction decode receives on an advance edge.
module tb_zap_prefetch_buffer;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_wb = 0, dstall = 0, clr_alu = 0, st_sh = 0, st_is = 0;
    logic f_valid = 0, f_abt = 0;
    logic [31:0] f_instr = 0, f_pc = 0;
    logic [1:0] f_taken = 0;
    logic ready, valid, abt;
    logic [35:0] instr;
    logic [31:0] pc, pc8;
    logic [1:0] taken;
    logic [2:0] count;
    int total = 0, bad = 0;
    logic [66:0] q[$];
    bit s_rst = 1, s_fl = 0, s_adv = 0, s_acc = 0;
    logic [66:0] s_word;

    zap_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst), .i_clear_from_writeback(clr_wb), .i_data_stall(dstall),
        .i_clear_from_alu(clr_alu), .i_stall_from_shifter(st_sh), .i_stall_from_issue(st_is),
        .i_fetch_valid(f_valid), .i_fetch_instr(f_instr), .i_fetch_pc(f_pc),
        .i_fetch_abt(f_abt), .i_fetch_taken(f_taken), .o_fetch_ready(ready),
        .o_instruction(instr), .o_instruction_valid(valid), .o_pc_ff(pc),
        .o_pc_plus_8_ff(pc8), .o_abt_ff(abt), .o_taken_ff(taken), .o_count(count)
    );

    always #5 clk = ~clk;

    // Occupancy/ready checks and capture of what the next edge will see.
    always @(negedge clk) begin
        total += 2;
        if (count !== 3'(q.size())) begin
            bad++;
            $display("FAIL sb_count: got %0d want %0d", count, q.size());
        end
        if (ready !== (!rst && q.size() != DEPTH)) begin
            bad++;
            $display("FAIL sb_ready: got %b want %b", ready, !rst && q.size() != DEPTH);
        end
        s_rst = rst;
        s_fl = clr_wb | (clr_alu & !dstall);
        s_adv = !s_fl & !(dstall | st_sh | st_is);
        s_acc = f_valid & ready & !s_fl;
        s_word = {f_instr, f_pc, f_abt, f_taken};
    end

    always @(posedge clk) begin
        logic [66:0] e;
        #1;
        if (s_rst || s_fl) q.delete();
        else begin
            if (s_acc) q.push_back(s_word);
            if (s_adv && valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_order: unexpected instr %h", instr);
                end else begin
                    e = q.pop_front();
                    if ({instr, pc, pc8, abt, taken} !== {4'd0, e[66:35], e[34:3], e[34:3] + 32'd8, e[2:0]}) begin
                        bad++;
                        $display("FAIL sb_order: got %h/%h/%h/%b/%b want %h/%h/%b/%b",
                                 instr, pc, pc8, abt, taken, e[66:35], e[34:3], e[2], e[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 4 && !valid; i++) tick();
        total++;
        if (valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_wait: got valid=%b want 1", name, valid);
        end
    endtask

    task automatic test_reset();
        f_valid = 1; f_instr = 32'hDEAD0000; f_pc = 32'h40;
        tick(); tick();
        total += 2;
        if ({valid, instr, pc, pc8, abt, taken} !== '0) begin
            bad++;
            $display("FAIL reset_outs: got %b %h %h %h %b %b want zeros", valid, instr, pc, pc8, abt, taken);
        end
        if (ready !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL reset_ready: got ready=%b count=%0d want 0 0", ready, count);
        end
        f_valid = 0;
        rst = 0;
        #1;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got ready=%b want 1", ready);
        end
    endtask

    task automatic test_first_word();
        f_valid = 1; f_instr = 32'hE3A00001; f_pc = 32'h100;
        tick();
        f_valid = 0;
        total++;
`ifdef ZAP_PREFETCH_BYPASS_EN
        if (valid !== 1'b1) begin
`else
        if (valid !== 1'b0) begin
`endif
            bad++;
            $display("FAIL first_latency: got valid=%b after edge 1", valid);
        end
`ifndef ZAP_PREFETCH_BYPASS_EN
        tick();
`endif
        total++;
        if (valid !== 1'b1 || instr !== 36'h0E3A00001 || pc8 !== 32'h108) begin
            bad++;
            $display("FAIL first_word: got %b %h %h want 1 0e3a00001 108", valid, instr, pc8);
        end
        tick();
        total++;
        if (valid !== 1'b0 || pc !== 32'h100) begin
            bad++;
            $display("FAIL first_drain: got valid=%b pc=%h want 0 100", valid, pc);
        end
    endtask

    task automatic test_fill();
        st_is = 1;
        for (int i = 0; i < 5; i++) begin
            f_valid = 1; f_instr = 32'hA000_0000 + i; f_pc = 32'h200 + 4 * i;
            tick();
        end
        total++;
        if (count !== 3'd4 || ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: got count=%0d ready=%b want 4 0", count, ready);
        end
        st_is = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (valid !== 1'b1 || instr !== {4'd0, 32'hA000_0000 + k}) begin
                bad++;
                $display("FAIL fill_order%0d: got %b %h want 1 %h", k, valid, instr, 32'hA000_0000 + k);
            end
            if (k == 1) f_valid = 0;
        end
        tick();
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL fill_empty: got valid=%b want 0", valid);
        end
    endtask

    task automatic test_flush();
        st_is = 1;
        for (int i = 0; i < 3; i++) begin
            f_valid = 1; f_instr = 32'hB000_0000 + i; f_pc = 32'h300 + 4 * i; f_abt = 1; f_taken = 2'b11;
            tick();
        end
        f_abt = 0; f_taken = 0;
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL flush_pre: got count=%0d want 3", count);
        end
        st_is = 0; clr_alu = 1; f_instr = 32'hBBBB_BBBB;
        tick();
        clr_alu = 0; f_valid = 0;
        total++;
        if (count !== 3'd0 || valid !== 1'b0 || abt !== 1'b0 || taken !== 2'b00) begin
            bad++;
            $display("FAIL flush: got count=%0d valid=%b abt=%b taken=%b want 0 0 0 0", count, valid, abt, taken);
        end
        tick();
        total++;
        if (count !== 3'd0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drop: got count=%0d valid=%b want 0 0", count, valid);
        end
    endtask

    task automatic test_priority();
        f_valid = 1; f_instr = 32'hC0C0_0001; f_pc = 32'h400;
        tick();
        f_valid = 0;
        wait_valid("prio");
        clr_alu = 1; dstall = 1; f_valid = 1; f_instr = 32'hC0C0_0002; f_pc = 32'h404;
        tick();
        f_valid = 0;
        total++;
        if (valid !== 1'b1 || instr !== 36'h0C0C00001 || count !== 3'd1) begin
            bad++;
            $display("FAIL prio_hold: got %b %h count=%0d want 1 0c0c00001 1", valid, instr, count);
        end
        clr_wb = 1;
        tick();
        clr_wb = 0; clr_alu = 0; dstall = 0;
        total++;
        if (valid !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL prio_wb: got valid=%b count=%0d want 0 0", valid, count);
        end
    endtask

    task automatic test_wrap_flags();
        f_valid = 1; f_instr = 32'hD000_0001; f_pc = 32'hFFFF_FFFC; f_abt = 1; f_taken = 2'b10;
        tick();
        f_valid = 0; f_abt = 0; f_taken = 0;
        wait_valid("wrap");
        total++;
        if (pc8 !== 32'h4 || abt !== 1'b1 || taken !== 2'b10 || pc !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_flags: got pc8=%h abt=%b taken=%b want 00000004 1 10", pc8, abt, taken);
        end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        for (int i = 0; i < 10; i++) begin
            f_valid = (i < 6); f_instr = 32'hE000_0000 + i; f_pc = 32'h500 + 4 * i;
            tick();
            total++;
            if (count > 3'd4) begin
                bad++;
                $display("FAIL b2b_count: got %0d want <=4", count);
            end
            if (valid === 1'b1) begin
                total++;
                if (instr !== {4'd0, 32'hE000_0000 + seen}) begin
                    bad++;
                    $display("FAIL b2b_order: got %h want %h", instr, 32'hE000_0000 + seen);
                end
                seen++;
            end
        end
        f_valid = 0;
        total++;
        if (seen != 6) begin
            bad++;
            $display("FAIL b2b_seen: got %0d want 6", seen);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_fill();
        test_flush();
        test_priority();
        test_wrap_flags();
        test_back_to_back();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
